// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer: response-side BIST signature analyzer.
// Compacts NPAT valid CUT responses into a MISR that uses the same feedback
// tap as the 4-bit LFSR pattern generator (sig[NBIT-1] ^ sig[NBIT-2]).
// At the end of the run it compares the signature against golden and
// reports pass/fail.
// Optional feature macro: MISR_SCAN_EN. When it is defined, the signature
// can be shifted serially in IDLE/DONE. scan_out carries sig[NBIT-1].
module misr_sig_analyzer #(
    parameter int              NBIT = 4,
    parameter logic [NBIT-1:0] SEED = {NBIT{1'b0}},
    parameter int              NPAT = 16,
    parameter int              CW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            data_valid,
    input  logic [NBIT-1:0] data_in,
    input  logic [NBIT-1:0] golden,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [NBIT-1:0] signature,
    input  logic            shift_en,
    input  logic            scan_in,
    output logic            scan_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Count value of the final response in a run.
    localparam logic [CW-1:0] LAST_CNT = CW'(NPAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // One MISR step: shift in the generator feedback, then fold in the response.
    function automatic logic [NBIT-1:0] misr_step(input logic [NBIT-1:0] s,
                                                  input logic [NBIT-1:0] d);
        misr_step = {s[NBIT-2:0], s[NBIT-1] ^ s[NBIT-2]} ^ d;
    endfunction

    state_t          state_r, state_s;
    logic [NBIT-1:0] sig_r, sig_s, step_s;
    logic [CW-1:0]   count_r, count_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            pass_r, pass_s;
    logic            shift_s;

`ifdef MISR_SCAN_EN
    assign shift_s  = shift_en;
    assign scan_out = sig_r[NBIT-1];
`else
    // Without the scan feature, the serial inputs have no function.
    logic unused_scan_s;
    assign unused_scan_s = shift_en ^ scan_in;
    assign shift_s       = 1'b0;
    assign scan_out      = 1'b0;
`endif

    assign step_s = misr_step(sig_r, data_in);

    // Next-state, signature, counter and status computation.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        count_s = count_r;
        busy_s  = busy_r;
        done_s  = done_r;
        pass_s  = pass_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Start has priority over both shift and data.
                    state_s = ST_COMPACT;
                    sig_s   = SEED;
                    count_s = {CW{1'b0}};
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end else if (shift_s) begin
                    sig_s = {sig_r[NBIT-2:0], scan_in};
                end else begin
                    sig_s = sig_r;
                end
            end
            ST_COMPACT: begin
                if (data_valid) begin
                    sig_s   = step_s;
                    count_s = count_r + CNT_ONE;
                    if (count_r == LAST_CNT) begin
                        // The final response lands on the same edge as DONE entry.
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (step_s == golden);
                    end else begin
                        state_s = ST_COMPACT;
                    end
                end else begin
                    sig_s = sig_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sig_s   = SEED;
                count_s = {CW{1'b0}};
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            sig_r   <= SEED;
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sig_r   <= sig_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_r;

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// Testbench for misr_sig_analyzer (NPAT=3, SEED=0).
// It runs directed scenarios with hand-computed signatures, then randomized
// traffic. A behavioural model and a per-cycle compare process check both.
module tb_misr_sig_analyzer;

    localparam int         NBIT = 4;
    localparam int         NPAT = 3;
    localparam int         CW   = 8;
    localparam logic [3:0] SEED = 4'h0;

    logic       clk;
    logic       rst;
    logic       start;
    logic       data_valid;
    logic [3:0] data_in;
    logic [3:0] golden;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;
    logic       shift_en;
    logic       scan_in;
    logic       scan_out;

    int n_vec;
    int n_err;

    misr_sig_analyzer #(.NBIT(NBIT), .SEED(SEED), .NPAT(NPAT), .CW(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid),
        .data_in(data_in), .golden(golden), .busy(busy), .done(done),
        .pass(pass), .signature(signature), .shift_en(shift_en),
        .scan_in(scan_in), .scan_out(scan_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the generator polynomial step, written arithmetically.
    function automatic int ref_step(input int s, input int d);
        int fb;
        fb = ((s >> 3) ^ (s >> 2)) & 1;
        return (((s << 1) & 15) | fb) ^ (d & 15);
    endfunction

    // Behavioural model: a run is a number of responses still to absorb.
    int m_sig, m_left;
    bit m_run, m_done, m_pass;

    // Model update on each clock edge.
    always @(posedge clk or negedge rst) begin
        int nxt;
        if (!rst) begin
            m_sig <= SEED; m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_left <= 0;
        end else if (!m_run) begin
            if (start) begin
                m_sig <= SEED; m_run <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0; m_left <= NPAT;
            end
`ifdef MISR_SCAN_EN
            else if (shift_en) m_sig <= ((m_sig << 1) & 15) | int'(scan_in);
`endif
        end else if (data_valid) begin
            nxt = ref_step(m_sig, int'(data_in));
            m_sig  <= nxt;
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_run <= 1'b0; m_done <= 1'b1; m_pass <= (nxt == int'(golden));
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("cyc_signature", signature, m_sig);
        chk("cyc_busy", busy, m_run);
        chk("cyc_done", done, m_done);
        if (m_done) chk("cyc_pass", pass, m_pass);
`ifdef MISR_SCAN_EN
        chk("cyc_scan_out", scan_out, (m_sig >> 3) & 1);
`else
        chk("cyc_scan_out", scan_out, 0);
`endif
    end

    task automatic cyc(input logic st, input logic dv, input logic [3:0] d);
        start = st; data_valid = dv; data_in = d;
        @(posedge clk);
        #1;
        start = 1'b0; data_valid = 1'b0;
    endtask

    logic [3:0] scan_exp;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = 4'h0;
        golden = 4'h0; shift_en = 1'b0; scan_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig", signature, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        rst = 1'b1;

        // Responses offered in IDLE are ignored.
        cyc(1'b0, 1'b1, 4'hF);
        cyc(1'b0, 1'b1, 4'hF);
        chk("idle_ignore_sig", signature, 4'h0);
        chk("idle_busy", busy, 1'b0);

        // start + valid together: start wins, that data is not compacted.
        golden = 4'h4;
        cyc(1'b1, 1'b1, 4'h5);
        chk("start_busy", busy, 1'b1);
        chk("start_sig", signature, 4'h0);
        cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b1, 1'b0, 4'h0);
        chk("busy_start_ignored", signature, 4'h1);
        cyc(1'b0, 1'b1, 4'h0);
        chk("before_last_done", done, 1'b0);
        chk("mid_sig", signature, 4'h2);
        cyc(1'b0, 1'b1, 4'h0);
        chk("run1_done", done, 1'b1);
        chk("run1_pass", pass, 1'b1);
        chk("run1_sig", signature, 4'h4);
        chk("run1_busy", busy, 1'b0);

        // pass is held against later golden changes; data ignored in DONE.
        golden = 4'h5;
        repeat (3) cyc(1'b0, 1'b1, 4'hF);
        chk("done_hold_sig", signature, 4'h4);
        chk("done_hold_pass", pass, 1'b1);

        // Restart from DONE, then the same data against the wrong golden.
        cyc(1'b1, 1'b0, 4'h0);
        chk("restart_done", done, 1'b0);
        chk("restart_sig", signature, 4'h0);
        cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        chk("run2_done", done, 1'b1);
        chk("run2_pass", pass, 1'b0);
        chk("run2_sig", signature, 4'h4);

`ifdef MISR_SCAN_EN
        // Shift the signature out MSB first while shifting ones in.
        scan_exp = 4'b0010;
        shift_en = 1'b1; scan_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("scan_out_seq", scan_out, scan_exp[i]);
            cyc(1'b0, 1'b0, 4'h0);
        end
        shift_en = 1'b0;
        chk("scan_final_sig", signature, 4'hF);
        chk("scan_done", done, 1'b1);
`else
        scan_exp = 4'h0;
        shift_en = 1'b1; scan_in = 1'b1;
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0);
        shift_en = 1'b0;
        chk("noscan_sig", signature, 4'h4);
        chk("noscan_out", scan_out, scan_exp[0]);
`endif

        // Valid responses separated by idle gaps.
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'h0);
            chk("gap_busy", busy, 1'b1);
            chk("gap_done", done, 1'b0);
        end
        chk("gap_sig1", signature, 4'hF);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (3) cyc(1'b0, 1'b0, 4'h0);
        chk("gap_sig2", signature, 4'hE);
        chk("gap_done2", done, 1'b0);
        cyc(1'b0, 1'b1, 4'h0);
        chk("gap_sig3", signature, 4'hC);
        chk("gap_done3", done, 1'b1);

        // Asynchronous reset in the middle of a run.
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sig", signature, 4'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b1, 4'hF);
        chk("post_rst_idle_sig", signature, 4'h0);
        chk("post_rst_idle_busy", busy, 1'b0);

        // Randomized traffic checked by the model and the compare process.
        for (int n = 0; n < 3000; n++) begin
            start      = ($urandom_range(0, 15) == 0);
            data_valid = $urandom_range(0, 1);
            data_in    = 4'($urandom_range(0, 15));
            shift_en   = ($urandom_range(0, 3) == 0);
            scan_in    = $urandom_range(0, 1);
            if (m_run && m_left == 1 && $urandom_range(0, 1) == 1)
                golden = 4'(ref_step(m_sig, int'(data_in)));
            else
                golden = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; data_valid = 1'b0; shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
